// File: rtl/conv_mac_scheduler.sv
// conv_mac_scheduler
//   Computes the full linear convolution y[n] = sum_k x[k]*h[n-k] of two stored
//   sample vectors. It drives one shared signed multiplier through a clear/launch/done
//   handshake and issues one product per multiplier run. Products are accumulated per
//   output index, and y[0..N_X+N_H-2] is streamed out with a valid strobe.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   ld_x, ld_h           sample writes into x/h (ignored while busy, ld_x wins)
//   ld_addr, ld_data     sample index / signed sample
//   start                begin a run (accepted only when idle)
//   mul_clr, mul_sel     one-cycle clear and launch pulses to the multiplier
//   mul_q, mul_m         operands x[k], h[n-k], held from clear until the product returns
//   mul_done, mul_out    multiplier completion and signed product
//   y_valid, y_data,     one-cycle output strobe, accumulated y[n] and its index n
//   y_index
//   busy, done, err      run in progress, end-of-run pulse, sticky multiplier timeout
`timescale 1ns/1ps
module conv_mac_scheduler #(
  parameter int unsigned N_X     = 4,
  parameter int unsigned N_H     = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned ACC_W   = 19,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_x,
  input  logic               ld_h,
  input  logic [2:0]         ld_addr,
  input  logic [W-1:0]       ld_data,
  input  logic               start,
  output logic               mul_clr,
  output logic               mul_sel,
  output logic [W-1:0]       mul_q,
  output logic [W-1:0]       mul_m,
  input  logic               mul_done,
  input  logic [2*W-1:0]     mul_out,
  output logic               y_valid,
  output logic [ACC_W-1:0]   y_data,
  output logic [3:0]         y_index,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);
  localparam logic [3:0] NLast = 4'(N_X + N_H - 2);
  localparam logic [3:0] KMax  = 4'(N_X - 1);
  localparam logic [3:0] HOff  = 4'(N_H - 1);
  localparam logic [3:0] XLen  = 4'(N_X);
  localparam logic [3:0] HLen  = 4'(N_H);

  typedef enum logic [2:0] {
    StIdle, StClr, StLaunch, StWait, StAcc, StEmit, StFin
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       n_q, n_d;
  logic [3:0]       k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             err_q, err_d;

  // Storage is sized for the maximum length so a 3-bit index always lands in range.
  logic [W-1:0]     x_q [8];
  logic [W-1:0]     h_q [8];

  logic [2:0]       h_idx;
  logic [3:0]       k_hi;
  logic             opnd_en;
  logic [ACC_W-1:0] prod_ext;

  // First k contributing to output n.
  function automatic logic [3:0] k_lo(input logic [3:0] n);
    return (n >= HOff) ? (n - HOff) : 4'd0;
  endfunction

  assign k_hi     = (n_q < KMax) ? n_q : KMax;
  assign h_idx    = 3'(n_q - k_q);
  assign prod_ext = {{(ACC_W - 2*W){prod_q[2*W-1]}}, prod_q};
  assign opnd_en  = (state_q == StClr) || (state_q == StLaunch) || (state_q == StWait);

  assign busy    = (state_q != StIdle) && (state_q != StFin);
  assign err     = err_q;
  assign mul_q   = opnd_en ? x_q[k_q[2:0]] : '0;
  assign mul_m   = opnd_en ? h_q[h_idx] : '0;
  assign y_data  = (state_q == StEmit) ? acc_q : '0;
  assign y_index = (state_q == StEmit) ? n_q : '0;

  // Sample register files; writes beyond the vector length are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else if (!busy) begin
      if (ld_x) begin
        if ({1'b0, ld_addr} < XLen) x_q[ld_addr] <= ld_data;
      end else if (ld_h) begin
        if ({1'b0, ld_addr} < HLen) h_q[ld_addr] <= ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    mul_clr = 1'b0;
    mul_sel = 1'b0;
    y_valid = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = StClr;
        end
      end
      StClr: begin
        mul_clr = 1'b1;
        state_d = StLaunch;
      end
      StLaunch: begin
        mul_sel = 1'b1;
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mul_done) begin
          prod_d  = mul_out;
          state_d = StAcc;
        end else if (tcnt_q == TLast) begin
          // Give up on this product: flag it and keep the run moving.
          err_d   = 1'b1;
          prod_d  = '0;
          state_d = StAcc;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StAcc: begin
        acc_d = acc_q + prod_ext;
        if (k_q == k_hi) begin
          state_d = StEmit;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = StClr;
        end
      end
      StEmit: begin
        y_valid = 1'b1;
        if (n_q == NLast) begin
          state_d = StFin;
        end else begin
          n_d     = n_q + 4'd1;
          k_d     = k_lo(n_q + 4'd1);
          acc_d   = '0;
          state_d = StClr;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_conv_mac_scheduler.sv
`timescale 1ns/1ps
module tb_conv_mac_scheduler;

  logic        clk = 1'b0;
  logic        rst, ld_x, ld_h, start, mul_done;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        mul_clr, mul_sel, y_valid, busy, done, err;
  logic [7:0]  mul_q, mul_m;
  logic signed [15:0] mul_out;
  logic [18:0] y_data;
  logic [3:0]  y_index;

  conv_mac_scheduler dut (
    .clk(clk), .rst(rst), .ld_x(ld_x), .ld_h(ld_h), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .mul_clr(mul_clr), .mul_sel(mul_sel), .mul_q(mul_q), .mul_m(mul_m),
    .mul_done(mul_done), .mul_out(mul_out), .y_valid(y_valid), .y_data(y_data),
    .y_index(y_index), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of expected outputs.
  int exp_data[$];
  int exp_idx[$];
  int y_cnt = 0;
  int done_cnt = 0;
  int ed, ei;

  task automatic push_exp(input int e[7]);
    for (int i = 0; i < 7; i++) begin
      exp_data.push_back(e[i]);
      exp_idx.push_back(i);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (y_valid) begin
      y_cnt++;
      if (exp_data.size() == 0) begin
        check("y_extra", 1, 0);
      end else begin
        ed = exp_data.pop_front();
        ei = exp_idx.pop_front();
        check("y_data", $signed(y_data), ed);
        check("y_index", y_index, ei);
      end
    end
  end

  // Multiplier model: product returned lat cycles after launch, or never.
  int  lat_min = 10, lat_max = 10;
  bit  never = 0;
  bit  pend = 0;
  int  mcnt = 0;
  bit  clr_prev = 0;
  int  sel_cnt = 0;
  int  clr_viol = 0;
  logic signed [7:0] op_q, op_m;

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (rst) begin
      pend = 0;
    end else if (mul_sel) begin
      sel_cnt++;
      if (!clr_prev) clr_viol++;
      pend = 1;
      mcnt = $urandom_range(lat_max, lat_min);
      op_q = mul_q;
      op_m = mul_m;
    end else if (pend && !never) begin
      mcnt--;
      if (mcnt <= 0) begin
        mul_out  = op_q * op_m;
        mul_done = 1'b1;
        pend     = 0;
      end
    end
    clr_prev = mul_clr;
  end

  task automatic load(input bit is_h, input int a, input int d);
    @(posedge clk);
    #1;
    ld_x    = !is_h;
    ld_h    = is_h;
    ld_addr = 3'(a);
    ld_data = 8'(d);
    @(posedge clk);
    #1;
    ld_x = 1'b0;
    ld_h = 1'b0;
  endtask

  task automatic load_vecs(input int xv[4], input int hv[4]);
    for (int i = 0; i < 4; i++) begin
      load(1'b0, i, xv[i]);
      load(1'b1, i, hv[i]);
    end
  endtask

  // Start a run, wait for its done pulse, then confirm the scoreboard drained.
  task automatic run(input bit exp_err, input bit interfere);
    int  d0;
    bit  seen;
    d0   = done_cnt;
    seen = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (interfere && i == 20) begin
        start   = 1'b1;
        ld_x    = 1'b1;
        ld_addr = 3'd0;
        ld_data = 8'd100;
      end else if (interfere && i == 21) begin
        start = 1'b0;
        ld_x  = 1'b0;
      end
      if (done) begin
        check("busy_at_done", busy, 0);
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("scoreboard_empty", exp_data.size(), 0);
    check("err_after_run", err, exp_err);
    check("idle_after_run", busy, 0);
  endtask

  int xa[4], ha[4], e1[7], e2[7], e3[7], ez[7];
  int s0, y0;
  bit hit;

  initial begin
    #500000;
    check("watchdog", 0, 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ld_x = 1'b0; ld_h = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    mul_done = 1'b0; mul_out = '0;
    e1 = '{1, 3, 6, 10, 9, 7, 4};
    e2 = '{16384, 32768, 49152, 65536, 49152, 32768, 16384};
    e3 = '{6, -10, 11, 17, -27, 28, 0};
    ez = '{0, 0, 0, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_err", err, 0);
    check("rst_mul_pulses", {mul_clr, mul_sel}, 0);
    check("rst_operands", {mul_q, mul_m}, 0);
    check("rst_y", {y_data, y_index}, 0);
    rst = 1'b0;

    // Ramp against ones, fixed latency.
    xa = '{1, 2, 3, 4}; ha = '{1, 1, 1, 1};
    load_vecs(xa, ha);
    push_exp(e1);
    run(1'b0, 1'b0);

    // Most negative operands: checks accumulator headroom.
    xa = '{-128, -128, -128, -128}; ha = '{-128, -128, -128, -128};
    load_vecs(xa, ha);
    push_exp(e2);
    run(1'b0, 1'b0);

    // Mixed signs, random latency, handshake ordering.
    xa = '{3, -5, 7, 0}; ha = '{2, 0, -1, 4};
    load_vecs(xa, ha);
    lat_min = 9; lat_max = 17;
    s0 = sel_cnt;
    push_exp(e3);
    run(1'b0, 1'b0);
    check("mul_sel_count", sel_cnt - s0, 16);
    check("clr_before_sel", clr_viol, 0);

    // start and ld_x while busy must be ignored, then a clean rerun matches.
    push_exp(e3);
    run(1'b0, 1'b1);
    push_exp(e3);
    run(1'b0, 1'b0);

    // Multiplier never answers: every product times out.
    never = 1;
    push_exp(ez);
    run(1'b1, 1'b0);
    never = 0;
    push_exp(e3);
    run(1'b0, 1'b0);

    // Reset after y[2]: abort, outputs zero, sample files cleared.
    push_exp(e3);
    y0 = y_cnt;
    hit = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (y_cnt - y0 >= 3) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check("reset_point_timeout", 0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_data.delete();
    exp_idx.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_outputs", {mul_clr, mul_sel, mul_q, mul_m, y_valid, y_data, y_index,
                             done, err}, 0);
    s0 = y_cnt;
    repeat (40) @(negedge clk);
    check("midrst_no_y", y_cnt - s0, 0);
    push_exp(ez);
    run(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
